// File: rtl/pixel_pkg.sv
// Shared constants, pixel type and serializer state encoding for the
// Mandelbrot output pipeline.
package pixel_pkg;

  localparam int RBG_SIZE    = 24;
  localparam int NUM_ENGINES = 12;
  localparam int X_SIZE      = 640;
  localparam int Y_SIZE      = 480;

  typedef logic [RBG_SIZE-1:0] rgb_t;

  typedef enum logic {
    IDLE,
    SHIFT
  } ser_state_e;

endpackage

// File: rtl/pixel_pos_counter.sv
// Raster position tracker: x/y counters that step on `advance`, with
// start-of-frame, end-of-line and end-of-frame flags for the current position.
module pixel_pos_counter #(
  parameter int X_SIZE = pixel_pkg::X_SIZE,
  parameter int Y_SIZE = pixel_pkg::Y_SIZE
) (
  input  logic clk,
  input  logic rst,
  input  logic advance,
  output logic sof,
  output logic eol,
  output logic eof
);

  localparam int X_W = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
  localparam int Y_W = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;
  localparam logic [X_W-1:0] X_LAST = X_W'(X_SIZE - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(Y_SIZE - 1);

  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    x_d = x_q;
    y_d = y_q;
    if (advance) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + Y_W'(1);
      end else begin
        x_d = x_q + X_W'(1);
      end
    end
  end

  // NOTE: state uses non-blocking assignments; reset here is synchronous, sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign sof = (x_q == '0) && (y_q == '0);
  assign eol = (x_q == X_LAST);
  assign eof = eol && (y_q == Y_LAST);

endmodule

// File: rtl/pixel_serializer.sv
// Turns NUM_ENGINES-wide colour batches into a one-pixel-per-cycle stream with
// raster flags. Define PIXEL_SER_FRAME_CNT_EN to add the frame_count output.
module pixel_serializer #(
  parameter int RBG_SIZE    = pixel_pkg::RBG_SIZE,
  parameter int NUM_ENGINES = pixel_pkg::NUM_ENGINES,
  parameter int X_SIZE      = pixel_pkg::X_SIZE,
  parameter int Y_SIZE      = pixel_pkg::Y_SIZE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                batch_valid,
  input  logic [RBG_SIZE-1:0] rgb_val [NUM_ENGINES],
  output logic                batch_ready,
  output logic [RBG_SIZE-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_sof,
  output logic                out_eol
`ifdef PIXEL_SER_FRAME_CNT_EN
  ,
  output logic [15:0]         frame_count
`endif
);

  import pixel_pkg::*;

  localparam int IDX_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_ENGINES - 1);

  ser_state_e          state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [RBG_SIZE-1:0] batch_q [NUM_ENGINES];
  logic [RBG_SIZE-1:0] batch_d [NUM_ENGINES];

  logic xfer, accept;
  logic sof, eol, eof;

  always_comb begin
    out_valid   = (state_q == SHIFT);
    out_data    = batch_q[idx_q];
    // Refill is allowed while the last element leaves, so batches stream gap-free.
    batch_ready = (state_q == IDLE) || ((idx_q == IDX_LAST) && out_ready);
    xfer        = out_valid && out_ready;
    accept      = batch_valid && batch_ready;
    out_sof     = out_valid && sof;
    out_eol     = out_valid && eol;

    state_d = state_q;
    idx_d   = idx_q;
    batch_d = batch_q;
    if (xfer) begin
      if (idx_q == IDX_LAST) begin
        state_d = IDLE;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
    if (accept) begin
      batch_d = rgb_val;
      idx_d   = '0;
      state_d = SHIFT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      // NOTE: the batch register is cleared on reset because out_data must read 0 out of reset.
      batch_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      batch_q <= batch_d;
    end
  end

  pixel_pos_counter #(
    .X_SIZE (X_SIZE),
    .Y_SIZE (Y_SIZE)
  ) u_pos (
    .clk     (clk),
    .rst     (rst),
    .advance (xfer),
    .sof     (sof),
    .eol     (eol),
    .eof     (eof)
  );

`ifdef PIXEL_SER_FRAME_CNT_EN
  logic [15:0] frame_count_q, frame_count_d;

  always_comb begin
    frame_count_d = frame_count_q;
    if (xfer && eof) frame_count_d = frame_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) frame_count_q <= '0;
    else     frame_count_q <= frame_count_d;
  end

  assign frame_count = frame_count_q;
`else
  logic unused_eof;
  assign unused_eof = eof;
`endif

endmodule

// File: tb/tb_pixel_serializer.sv
// Randomised bench for pixel_serializer: a small-raster instance checked every
// cycle against a queue model, plus a default-size instance with literal checks.
module tb_pixel_serializer;

  localparam int TW = 24;
  localparam int TN = 4;
  localparam int TX = 10;
  localparam int TY = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Small-raster instance
  logic          rst, batch_valid, batch_ready, out_valid, out_ready, out_sof, out_eol;
  logic [TW-1:0] rgb_val [TN];
  logic [TW-1:0] out_data;
`ifdef PIXEL_SER_FRAME_CNT_EN
  logic [15:0]   frame_count;
`endif

  pixel_serializer #(
    .RBG_SIZE    (TW),
    .NUM_ENGINES (TN),
    .X_SIZE      (TX),
    .Y_SIZE      (TY)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .batch_valid (batch_valid),
    .rgb_val     (rgb_val),
    .batch_ready (batch_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sof     (out_sof),
    .out_eol     (out_eol)
`ifdef PIXEL_SER_FRAME_CNT_EN
    ,
    .frame_count (frame_count)
`endif
  );

  // Default-size instance
  logic          big_rst, big_bv, big_br, big_valid, big_oready, big_sof, big_eol;
  logic [23:0]   big_rgb [12];
  logic [23:0]   big_data;
`ifdef PIXEL_SER_FRAME_CNT_EN
  logic [15:0]   big_fc;
`endif

  pixel_serializer dut_big (
    .clk         (clk),
    .rst         (big_rst),
    .batch_valid (big_bv),
    .rgb_val     (big_rgb),
    .batch_ready (big_br),
    .out_data    (big_data),
    .out_valid   (big_valid),
    .out_ready   (big_oready),
    .out_sof     (big_sof),
    .out_eol     (big_eol)
`ifdef PIXEL_SER_FRAME_CNT_EN
    ,
    .frame_count (big_fc)
`endif
  );

  // Reference model: FIFO of pending pixels and count of pixels sent since reset
  logic [TW-1:0] mq [$];
  int            pix_n = 0;
  bit            chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      pix_n = 0;
    end else begin
      bit rdy;
      rdy = (mq.size() == 0) || (mq.size() == 1 && out_ready);
      if (mq.size() > 0 && out_ready) begin
        void'(mq.pop_front());
        pix_n++;
      end
      if (batch_valid && rdy) foreach (rgb_val[i]) mq.push_back(rgb_val[i]);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      bit exp_valid;
      exp_valid = mq.size() > 0;
      check("out_valid", 32'(out_valid), 32'(exp_valid));
      check("batch_ready", 32'(batch_ready),
            32'((mq.size() == 0) || (mq.size() == 1 && out_ready)));
      if (exp_valid) begin
        check("out_data", 32'(out_data), 32'(mq[0]));
        check("out_sof", 32'(out_sof), 32'((pix_n % (TX * TY)) == 0));
        check("out_eol", 32'(out_eol), 32'((pix_n % TX) == TX - 1));
      end else begin
        check("out_sof_idle", 32'(out_sof), 32'(0));
        check("out_eol_idle", 32'(out_eol), 32'(0));
      end
`ifdef PIXEL_SER_FRAME_CNT_EN
      check("frame_count", 32'(frame_count), 32'((pix_n / (TX * TY)) % 65536));
`endif
    end
  end

  // Flagged pixels observed on transfers, for the literal raster checks
  logic [TW-1:0] eol_q [$];
  logic [TW-1:0] sof_q [$];

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (out_eol) eol_q.push_back(out_data);
      if (out_sof) sof_q.push_back(out_data);
    end
  end

  // out_ready driver: 0 = always ready, 1 = random, 2 = repeating 1,0,0,1
  int       ready_mode = 0;
  int       pat_i = 0;
  logic [3:0] pat = 4'b1001;

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       out_ready = ($urandom_range(0, 3) != 0);
        2: begin
          out_ready = pat[pat_i];
          pat_i = (pat_i + 1) % 4;
        end
        default: out_ready = 1'b1;
      endcase
    end
  end

  task automatic send_batch(input logic [TW-1:0] base, input bit rnd);
    int n;
    bit ok;
    n  = 0;
    ok = 1'b0;
    for (int i = 0; i < TN; i++) rgb_val[i] = rnd ? TW'($urandom) : base + TW'(i);
    batch_valid = 1'b1;
    while (!ok) begin
      @(negedge clk);
      ok = batch_ready;
      @(posedge clk);
      #1;
      n++;
      if (!ok && n > 200) begin
        check("batch_accept_timeout", 32'(0), 32'(1));
        break;
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (out_valid && n < 500);
    check("drain_timeout", 32'(out_valid), 32'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    rst         = 1'b1;
    batch_valid = 1'b0;
    foreach (rgb_val[i]) rgb_val[i] = '0;
    big_rst     = 1'b1;
    big_bv      = 1'b0;
    big_oready  = 1'b1;
    foreach (big_rgb[i]) big_rgb[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    rst     = 1'b0;
    big_rst = 1'b0;

    // Reset state, literal
    @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'(0));
    check("rst_ready", 32'(batch_ready), 32'(1));
    check("rst_data", 32'(out_data), 32'(0));
    check("rst_sof", 32'(out_sof), 32'(0));
    check("rst_eol", 32'(out_eol), 32'(0));
    check("big_rst_data", 32'(big_data), 32'(0));
    check("big_rst_ready", 32'(big_br), 32'(1));
`ifdef PIXEL_SER_FRAME_CNT_EN
    check("rst_frame_count", 32'(frame_count), 32'(0));
`endif
    chk_en = 1'b1;

    // Default-size instance: one batch 1..12 streams in order
    @(posedge clk);
    #1;
    for (int i = 0; i < 12; i++) big_rgb[i] = 24'(i + 1);
    big_bv = 1'b1;
    @(posedge clk);
    #1;
    big_bv = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("big_valid", 32'(big_valid), 32'(1));
      check("big_data", 32'(big_data), 32'(i + 1));
      check("big_sof", 32'(big_sof), 32'(i == 0));
      check("big_eol", 32'(big_eol), 32'(0));
      check("big_batch_ready", 32'(big_br), 32'(i == 11));
    end
    @(negedge clk);
    check("big_valid_end", 32'(big_valid), 32'(0));
    @(posedge clk);
    #1;

    // Back-to-back batches covering a frame and a bit: lines straddle batches
    eol_q.delete();
    sof_q.delete();
    ready_mode = 0;
    for (int b = 0; b < 16; b++) send_batch(TW'(b * TN + 1), 1'b0);
    batch_valid = 1'b0;
    drain();
    check("eol_count", 32'(eol_q.size()), 32'(6));
    if (eol_q.size() == 6) begin
      check("eol_first", 32'(eol_q[0]), 32'(10));
      check("eol_second", 32'(eol_q[1]), 32'(20));
      check("eol_last", 32'(eol_q[5]), 32'(60));
    end
    check("sof_count", 32'(sof_q.size()), 32'(2));
    if (sof_q.size() == 2) begin
      check("sof_first", 32'(sof_q[0]), 32'(1));
      check("sof_frame2", 32'(sof_q[1]), 32'(61));
    end
`ifdef PIXEL_SER_FRAME_CNT_EN
    check("frame_count_one", 32'(frame_count), 32'(1));
`endif

    // Stall pattern 1,0,0,1
    ready_mode = 2;
    for (int b = 0; b < 3; b++) send_batch('0, 1'b1);
    batch_valid = 1'b0;
    drain();

    // Random traffic over several frames
    ready_mode = 1;
    for (int b = 0; b < 60; b++) begin
      send_batch('0, 1'b1);
      if ($urandom_range(0, 2) == 0) begin
        batch_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    batch_valid = 1'b0;
    drain();

    // Reset in the middle of a batch
    ready_mode = 0;
    @(posedge clk);
    #1;
    send_batch(24'h0000A0, 1'b0);
    batch_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_valid", 32'(out_valid), 32'(0));
    @(posedge clk);
    #1;
    send_batch(24'h0000B0, 1'b0);
    batch_valid = 1'b0;
    @(negedge clk);
    check("post_rst_sof", 32'(out_sof), 32'(1));
    check("post_rst_data", 32'(out_data), 32'(24'h0000B0));
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_serializer.md
# pixel_serializer

Downstream stage of the colour LUT in the Mandelbrot pipeline: captures one batch of `NUM_ENGINES` RGB values per handshake and emits them one pixel per cycle on a valid/ready stream. The block keeps raster position, marks start-of-frame and end-of-line, and feeds the video output interface. Back-to-back batches are accepted with no bubble.

## Interface
- `RBG_SIZE`, 24, bits per RGB pixel
- `NUM_ENGINES`, 12, pixels per input batch (one per engine)
- `X_SIZE`, 640, pixels per line
- `Y_SIZE`, 480, lines per frame

- `clk`  in  1  single clock; all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `batch_valid`  in  1  `rgb_val` holds a complete batch
- `rgb_val`  in  `RBG_SIZE` x `NUM_ENGINES`  unpacked batch; index 0 is the leftmost pixel
- `batch_ready`  out  1  batch accepted on this edge if `batch_valid`
- `out_data`  out  `RBG_SIZE`  current pixel
- `out_valid`  out  1  `out_data` valid
- `out_ready`  in  1  sink accepts pixel
- `out_sof`  out  1  first pixel of frame (x==0, y==0), gated by `out_valid`
- `out_eol`  out  1  last pixel of line (x==`X_SIZE`-1), gated by `out_valid`

## Operation
- FSM states: IDLE (buffer empty), SHIFT (buffer holds a batch, element `idx` presented).
- Batch register: `NUM_ENGINES` x `RBG_SIZE`; index counter `idx` width `$clog2(NUM_ENGINES)`.
- `batch_ready` = IDLE, or (SHIFT and `idx`==`NUM_ENGINES`-1 and `out_ready`). Combinational from `out_ready`; no other input-to-output paths.
- Batch accept (`batch_valid && batch_ready`): load register, `idx` <- 0, state <- SHIFT.
- Pixel transfer (`out_valid && out_ready`): advance `idx`; at last index, go to IDLE unless a batch is accepted on the same edge (then reload, stay in SHIFT).
- `out_data` = register[`idx`]; `out_valid` = (state==SHIFT).
- Position counters x (`$clog2(X_SIZE)` bits), y (`$clog2(Y_SIZE)` bits) advance only on pixel transfer. x wraps `X_SIZE`-1 -> 0 and increments y. y wraps `Y_SIZE`-1 -> 0.
- Counters are independent of batch boundaries. A batch may straddle a line or frame end; the remaining pixels belong to the next line/frame.
- Stall: while `out_valid && !out_ready`, `out_data`, `out_sof`, `out_eol` and counters hold.
- `batch_valid` while not ready: batch is not taken, no state change; the upstream side holds the data.

## Timing
- Reset: state IDLE, `idx`=0, x=0, y=0, `out_valid`=0, `out_sof`=0, `out_eol`=0, `out_data`=0 (register cleared), `batch_ready`=1.
- Latency: batch accepted at edge N -> element 0 on `out_valid` in cycle after N.
- Throughput: 1 pixel/cycle with `out_ready` held high; a new batch accepted on the same edge as the last pixel transfer gives a continuous stream.
- `rst` asserted mid-batch: buffered pixels are discarded, counters are zeroed, and the next pixel after reset is flagged `out_sof`.

## Configuration
- `PIXEL_SER_FRAME_CNT_EN` defined: adds output `frame_count` [15:0], reset 0. It increments on the transfer of pixel (`X_SIZE`-1, `Y_SIZE`-1) and wraps at 16'hFFFF -> 0.
- Undefined: port and counter absent; all other behaviour identical.

## Structure
- Shared package `pixel_pkg`: `RBG_SIZE`, `X_SIZE`, `Y_SIZE` constants, `rgb_t` typedef (`logic [RBG_SIZE-1:0]`), and the FSM state enum.
- One sub-module, `pixel_pos_counter`: x/y raster counters with enable (`advance`), `sof`/`eol`/`eof` flags. This block is reused by the frame writer.

## Test plan
- Reset, then a batch of 12 pixels 0x000001..0x00000C with `out_ready`=1 -> 12 consecutive pixels in order. The first carries `out_sof`=1. `batch_ready`=0 during pixels 0..10.
- Two batches back-to-back with `out_ready`=1 -> 24 pixels with no gap in `out_valid`. The second batch is accepted on the same edge as pixel 11.
- `out_ready` toggled 1,0,0,1 during a batch -> `out_data`, `out_sof`/`out_eol` stable across the stall; no pixel lost or duplicated.
- Full frame of 640x480 at `NUM_ENGINES`=12 -> `out_eol` on every x=639. `out_sof` on the first pixel only, and again on pixel 0 of frame 2. With `PIXEL_SER_FRAME_CNT_EN`, `frame_count` becomes 1 after pixel (639,479).
- `X_SIZE`=10, `NUM_ENGINES`=4 -> `out_eol` on batch 2 element 1 and batch 4 element 3, confirming lines straddle batches.
- `rst` after 5 pixels of a batch -> `out_valid`=0 the next cycle. The next batch's pixel 0 carries `out_sof`=1.
